// File: rtl/cpu_pkg.sv
// Core-wide register file constants and writeback bundle.
// Shared by regfile, issue, hazard and writeback logic.
package cpu_pkg;

  localparam int REGISTER_WIDTH      = 32;
  localparam int REGISTER_ADDR_WIDTH = 5;
  localparam int NUM_REGS            = 2 ** REGISTER_ADDR_WIDTH;

  typedef struct packed {
    logic [REGISTER_ADDR_WIDTH-1:0] rd;
    logic [REGISTER_WIDTH-1:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO for long-latency writeback results.
// Extra pointer bit distinguishes full from empty; no bypass.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register file write-port arbiter: ALU vs queued long-latency results,
// with an anti-starvation counter and a long-latency pending scoreboard.
module wb_arbiter #(
  parameter int REGISTER_WIDTH      = cpu_pkg::REGISTER_WIDTH,
  parameter int REGISTER_ADDR_WIDTH = cpu_pkg::REGISTER_ADDR_WIDTH,
  parameter int LSU_FIFO_DEPTH      = 4,
  parameter int STARVE_LIMIT        = 3
) (
  input  logic                               cpu_clk,
  input  logic                               cpu_rst,
  input  logic                               iss_valid,
  input  logic                               iss_long,
  input  logic [REGISTER_ADDR_WIDTH-1:0]     iss_rd,
  output logic [2**REGISTER_ADDR_WIDTH-1:0]  sb_pending,
  input  logic                               alu_valid,
  output logic                               alu_ready,
  input  logic [REGISTER_ADDR_WIDTH-1:0]     alu_rd,
  input  logic [REGISTER_WIDTH-1:0]          alu_data,
  input  logic                               lsu_valid,
  output logic                               lsu_ready,
  input  logic [REGISTER_ADDR_WIDTH-1:0]     lsu_rd,
  input  logic [REGISTER_WIDTH-1:0]          lsu_data,
  output logic                               we,
  output logic [REGISTER_ADDR_WIDTH-1:0]     wd_addr,
  output logic [REGISTER_WIDTH-1:0]          wd_data
);

  localparam int NR = 2 ** REGISTER_ADDR_WIDTH;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [NR-1:0] NZ_MASK = {{(NR-1){1'b1}}, 1'b0};

  typedef struct packed {
    logic [REGISTER_ADDR_WIDTH-1:0] rd;
    logic [REGISTER_WIDTH-1:0]      data;
  } entry_t;

  entry_t                         push_e;
  entry_t                         head;
  logic                           full;
  logic                           empty;
  logic                           push;
  logic                           pop;
  logic                           force_lsu;
  logic                           alu_win;
  logic                           win_valid;
  logic [REGISTER_ADDR_WIDTH-1:0] win_rd;
  logic [REGISTER_WIDTH-1:0]      win_data;
  logic                           win_wr;
  logic [SW-1:0]                  starve;
  logic [NR-1:0]                  set_mask;
  logic [NR-1:0]                  clr_mask;
  logic [NR-1:0]                  pending_nxt;

  assign push_e = '{rd: lsu_rd, data: lsu_data};

  wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (cpu_clk),
    .rst   (cpu_rst),
    .push  (push),
    .pop   (pop),
    .din   (push_e),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // A starved head takes the slot regardless of the ALU.
  assign force_lsu = !empty && (starve == LIMIT);
  assign alu_ready = !force_lsu;
  assign lsu_ready = !full;
  assign push      = lsu_valid && !full;
  assign alu_win   = alu_valid && !force_lsu;
  assign pop       = !alu_win && !empty;
  assign win_valid = alu_win || pop;

  always_comb begin
    win_rd   = head.rd;
    win_data = head.data;
    if (alu_win) begin
      win_rd   = alu_rd;
      win_data = alu_data;
    end
  end

  assign win_wr = win_valid && (win_rd != '0);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && iss_long && (iss_rd != '0)) begin
      set_mask[iss_rd] = 1'b1;
    end
    if (pop) begin
      clr_mask[head.rd] = 1'b1;
    end
  end

  // Set is applied after clear so a same-cycle reissue stays pending.
  assign pending_nxt = ((sb_pending & ~clr_mask) | set_mask) & NZ_MASK;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      starve     <= '0;
      sb_pending <= '0;
      we         <= 1'b0;
      wd_addr    <= '0;
      wd_data    <= '0;
    end else begin
      sb_pending <= pending_nxt;
      if (empty || pop) begin
        starve <= '0;
      end else if (alu_win && (starve != LIMIT)) begin
        starve <= starve + SW'(1);
      end
      we <= win_wr;
      if (win_wr) begin
        wd_addr <= win_rd;
        wd_data <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

  localparam int AW    = 5;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int LIM   = 3;

  typedef struct {
    logic [AW-1:0] rd;
    logic [W-1:0]  data;
  } ent_t;

  logic            cpu_clk = 1'b0;
  logic            cpu_rst;
  logic            iss_valid;
  logic            iss_long;
  logic [AW-1:0]   iss_rd;
  logic [31:0]     sb_pending;
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [W-1:0]    alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [W-1:0]    lsu_data;
  logic            we;
  logic [AW-1:0]   wd_addr;
  logic [W-1:0]    wd_data;

  int checks = 0;
  int errors = 0;

  ent_t          q[$];
  int            m_starve;
  logic [31:0]   m_pend;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_data;

  wb_arbiter #(
    .REGISTER_WIDTH      (W),
    .REGISTER_ADDR_WIDTH (AW),
    .LSU_FIFO_DEPTH      (DEPTH),
    .STARVE_LIMIT        (LIM)
  ) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .iss_valid  (iss_valid),
    .iss_long   (iss_long),
    .iss_rd     (iss_rd),
    .sb_pending (sb_pending),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .we         (we),
    .wd_addr    (wd_addr),
    .wd_data    (wd_data)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic exp_alu_ready();
    return !(q.size() > 0 && m_starve == LIM);
  endfunction

  function automatic logic exp_lsu_ready();
    return q.size() < DEPTH;
  endfunction

  // One clock edge of the architectural behaviour, from the current inputs.
  task automatic model_step();
    int   n;
    bit   aw;
    bit   pp;
    ent_t h;
    ent_t e;
    if (cpu_rst) begin
      q.delete();
      m_starve = 0;
      m_pend   = '0;
      m_we     = 0;
      m_addr   = '0;
      m_data   = '0;
      return;
    end
    n    = q.size();
    aw   = alu_valid && !(n > 0 && m_starve == LIM);
    pp   = !aw && n > 0;
    m_we = 0;
    if (aw) begin
      if (alu_rd != 0) begin
        m_we = 1; m_addr = alu_rd; m_data = alu_data;
      end
    end else if (pp) begin
      h = q.pop_front();
      m_pend[h.rd] = 1'b0;
      if (h.rd != 0) begin
        m_we = 1; m_addr = h.rd; m_data = h.data;
      end
    end
    if (n == 0 || pp) m_starve = 0;
    else if (aw && m_starve < LIM) m_starve++;
    if (lsu_valid && n < DEPTH) begin
      e.rd = lsu_rd; e.data = lsu_data;
      q.push_back(e);
    end
    if (iss_valid && iss_long && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    m_pend[0] = 1'b0;
  endtask

  task automatic cycle();
    @(posedge cpu_clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_long = 0; iss_rd = '0;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
    cycle();
  endtask

  task automatic test_reset();
    int bad;
    idle();
    cpu_rst = 1;
    cycle(); cycle();
    cpu_rst = 0;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0h want 0", we); end
    checks++; if (wd_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h want 0", wd_addr); end
    checks++; if (wd_data !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", wd_data); end
    checks++; if (sb_pending !== '0) begin errors++; $display("FAIL reset_pending: got %0h want 0", sb_pending); end
    checks++; if (lsu_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b%0b want 11", alu_ready, lsu_ready); end
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'h22;
    iss_valid = 1; iss_long = 1; iss_rd = 5'd2;
    cycle();
    lsu_rd = 5'd3; lsu_data = 32'h33; iss_rd = 5'd3;
    cycle();
    idle();
    checks++; if (sb_pending !== 32'h0000_000C) begin errors++; $display("FAIL prereset_pending: got %0h want c", sb_pending); end
    cpu_rst = 1;
    cycle();
    cpu_rst = 0;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL midreset_we: got %0h want 0", we); end
    checks++; if (sb_pending !== '0) begin errors++; $display("FAIL midreset_pending: got %0h want 0", sb_pending); end
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL midreset_lsu_ready: got %0h want 1", lsu_ready); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (we !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midreset_nowrite: got %0d writes want 0", bad); end
  endtask

  task automatic test_alu_write();
    idle();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %0h want 1", alu_ready); end
    cycle();
    idle();
    checks++; if (we !== 1'b1 || wd_addr !== 5'd5 || wd_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL alu_write: got we=%0h a=%0d d=%0h want 1 5 deadbeef", we, wd_addr, wd_data); end
    cycle();
    checks++; if (we !== 1'b0 || wd_addr !== 5'd5 || wd_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL alu_hold: got we=%0h a=%0d d=%0h want 0 5 deadbeef", we, wd_addr, wd_data); end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_valid = 1; iss_long = 1; iss_rd = 5'd7;
    cycle();
    idle();
    checks++; if (sb_pending[7] !== 1'b1) begin errors++; $display("FAIL sb_set7: got %0h want 1", sb_pending[7]); end
    cycle(); cycle(); cycle();
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h1234;
    cycle();
    idle();
    checks++; if (sb_pending[7] !== 1'b1 || we !== 1'b0) begin
      errors++; $display("FAIL sb_push7: got p=%0h we=%0h want 1 0", sb_pending[7], we); end
    cycle();
    checks++; if (sb_pending[7] !== 1'b0 || we !== 1'b1 || wd_addr !== 5'd7 || wd_data !== 32'h1234) begin
      errors++; $display("FAIL sb_pop7: got p=%0h we=%0h a=%0d d=%0h want 0 1 7 1234", sb_pending[7], we, wd_addr, wd_data); end
  endtask

  task automatic test_starve();
    drain();
    alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hA0;
    lsu_valid = 1; lsu_rd = 5'd9;  lsu_data = 32'h9999;
    cycle();
    lsu_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL starve_win%0d: got %0h want 1", i, alu_ready); end
      alu_rd = 5'(11 + i); alu_data = 32'hA1 + i;
      cycle();
      checks++; if (we !== 1'b1 || wd_addr !== 5'(11 + i)) begin
        errors++; $display("FAIL starve_alu%0d: got we=%0h a=%0d want 1 %0d", i, we, wd_addr, 11 + i); end
    end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL starve_force: got %0h want 0", alu_ready); end
    cycle();
    checks++; if (we !== 1'b1 || wd_addr !== 5'd9 || wd_data !== 32'h9999) begin
      errors++; $display("FAIL starve_pop: got we=%0h a=%0d d=%0h want 1 9 9999", we, wd_addr, wd_data); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL starve_resume: got %0h want 1", alu_ready); end
    cycle();
    checks++; if (we !== 1'b1 || wd_addr !== 5'd13) begin
      errors++; $display("FAIL starve_after: got we=%0h a=%0d want 1 13", we, wd_addr); end
    idle();
  endtask

  task automatic test_full();
    logic [AW-1:0] got[$];
    int            n;
    drain();
    alu_valid = 1; alu_rd = 5'd10; alu_data = 32'h55;
    lsu_valid = 1;
    for (int k = 0; k < 4; k++) begin
      lsu_rd = 5'(20 + k); lsu_data = 32'hF00 + k;
      cycle();
    end
    checks++; if (lsu_ready !== 1'b0 || alu_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready: got l=%0h a=%0h want 0 0", lsu_ready, alu_ready); end
    lsu_rd = 5'd24; lsu_data = 32'hF04;
    cycle();
    if (we && wd_addr >= 20) got.push_back(wd_addr);
    checks++; if (lsu_ready !== 1'b1 || wd_addr !== 5'd20 || wd_data !== 32'hF00) begin
      errors++; $display("FAIL full_pop: got l=%0h a=%0d d=%0h want 1 20 f00", lsu_ready, wd_addr, wd_data); end
    cycle();
    lsu_valid = 0;
    checks++; if (wd_addr !== 5'd10 || m_addr !== 5'd10 || q.size() != 4) begin
      errors++; $display("FAIL full_repush: got a=%0d q=%0d want 10 4", wd_addr, q.size()); end
    n = 0;
    while (got.size() < 5 && n < 40) begin
      if (n == 12) alu_valid = 0;
      cycle();
      if (we && wd_addr >= 20) got.push_back(wd_addr);
      n++;
    end
    idle();
    checks++; if (got.size() != 5) begin errors++; $display("FAIL full_count: got %0d want 5", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      checks++; if (got[k] !== 5'(20 + k)) begin errors++; $display("FAIL full_order%0d: got %0d want %0d", k, got[k], 20 + k); end
    end
  endtask

  task automatic test_rd_zero();
    logic [AW-1:0] prev;
    drain();
    prev = wd_addr;
    alu_valid = 1; alu_rd = '0; alu_data = 32'hBAD0;
    lsu_valid = 1; lsu_rd = '0; lsu_data = 32'hBAD1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL rd0_alu_ready: got %0h want 1", alu_ready); end
    cycle();
    idle();
    checks++; if (we !== 1'b0 || wd_addr !== prev) begin errors++; $display("FAIL rd0_alu: got we=%0h a=%0d want 0 %0d", we, wd_addr, prev); end
    cycle();
    checks++; if (we !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL rd0_lsu: got we=%0h q=%0d want 0 0", we, q.size()); end
    iss_valid = 1; iss_long = 1; iss_rd = '0;
    cycle();
    idle();
    checks++; if (sb_pending !== '0) begin errors++; $display("FAIL rd0_sb: got %0h want 0", sb_pending); end
    iss_valid = 1; iss_long = 1; iss_rd = 5'd3;
    cycle();
    idle();
    lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'h33;
    cycle();
    idle();
    iss_valid = 1; iss_long = 1; iss_rd = 5'd3;
    cycle();
    idle();
    checks++; if (sb_pending[3] !== 1'b1 || we !== 1'b1 || wd_addr !== 5'd3) begin
      errors++; $display("FAIL sb_setwins: got p=%0h we=%0h a=%0d want 1 1 3", sb_pending[3], we, wd_addr); end
    lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'h34;
    cycle();
    idle();
    cycle();
    checks++; if (sb_pending[3] !== 1'b0) begin errors++; $display("FAIL sb_clear3: got %0h want 0", sb_pending[3]); end
  endtask

  task automatic test_random();
    bit alu_acc = 1;
    bit lsu_acc = 1;
    drain();
    for (int i = 0; i < 400; i++) begin
      if (alu_acc) begin
        alu_valid = ($urandom % 4) != 0; alu_rd = 5'($urandom); alu_data = $urandom;
      end
      if (lsu_acc) begin
        lsu_valid = ($urandom % 2) != 0; lsu_rd = 5'($urandom); lsu_data = $urandom;
      end
      iss_valid = ($urandom % 3) == 0; iss_long = ($urandom % 2) != 0; iss_rd = 5'($urandom);
      alu_acc = !alu_valid || exp_alu_ready();
      lsu_acc = !lsu_valid || exp_lsu_ready();
      cycle();
      checks++; if (we !== m_we) begin errors++; $display("FAIL rnd_we@%0d: got %0h want %0h", i, we, m_we); end
      checks++; if (wd_addr !== m_addr) begin errors++; $display("FAIL rnd_addr@%0d: got %0d want %0d", i, wd_addr, m_addr); end
      checks++; if (wd_data !== m_data) begin errors++; $display("FAIL rnd_data@%0d: got %0h want %0h", i, wd_data, m_data); end
      checks++; if (sb_pending !== m_pend) begin errors++; $display("FAIL rnd_pending@%0d: got %0h want %0h", i, sb_pending, m_pend); end
      checks++; if (alu_ready !== exp_alu_ready()) begin errors++; $display("FAIL rnd_alu_ready@%0d: got %0h want %0h", i, alu_ready, exp_alu_ready()); end
      checks++; if (lsu_ready !== exp_lsu_ready()) begin errors++; $display("FAIL rnd_lsu_ready@%0d: got %0h want %0h", i, lsu_ready, exp_lsu_ready()); end
    end
    idle();
  endtask

  initial begin
    cpu_rst = 1;
    idle();
    test_reset();
    test_alu_write();
    test_scoreboard();
    test_starve();
    test_full();
    test_rd_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
